// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported RAM between an instruction-fetch requester and a
// MEM-stage load/store requester. Each transaction runs IDLE -> ACCESS -> RESP.
// A new grant is accepted only in IDLE, and data requests take priority.
//
// Timing, counted from the grant edge:
//   read : ram_en in cycle 1, valid pulse in cycle RD_LATENCY+1
//   write: ram_en/ram_we in cycle 1, valid pulse in cycle 2
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add a starvation guard.
// With the guard, after STARVE_LIMIT consecutive data grants made while fetch
// was waiting, the next IDLE grant goes to fetch. Without the macro, data
// priority is strict and the counter does not exist.
//
// Parameters
//   RD_LATENCY   : RAM read latency in cycles (1..4)
//   STARVE_LIMIT : data grants tolerated while fetch waits (guard build only)
//
// Ports
//   clk, reset                    : clock (rising edge), async active-low reset
//   if_req, if_addr               : fetch request and PC
//   if_rdata, if_valid            : fetched word, one-cycle completion pulse
//   mem_rd, mem_wr                : load/store request (write wins if both set)
//   mem_addr, mem_wdata           : load/store address and store data
//   mem_rdata, mem_valid          : load data, one-cycle completion pulse
//   ram_en, ram_we                : shared RAM strobe and write enable
//   ram_addr, ram_wdata, ram_rdata: shared RAM address and data
//   stall_if, stall_mem           : pipeline hold requests (combinational)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("mem_port_arbiter: RD_LATENCY must be 1..4 and STARVE_LIMIT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  state_e      state_q;
  owner_e      owner_q;
  logic [2:0]  cnt_q;
  logic        ram_en_q;
  logic        ram_we_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_valid_q;
  logic        mem_valid_q;

  logic        data_req;
  logic        grant_data;
  logic        grant_fetch;

  assign data_req = mem_rd | mem_wr;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          starved;

  // Once fetch has lost STARVE_LIMIT times in a row, it wins the next grant.
  assign starved = (starve_q == SW'(STARVE_LIMIT));

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    starve_d    = starve_q;
    if (state_q == S_IDLE) begin
      grant_data  = data_req & ~(starved & if_req);
      grant_fetch = if_req & ~grant_data;
      if (grant_fetch) begin
        starve_d = '0;
      end else if (grant_data && if_req) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state_q == S_IDLE) begin
      grant_data  = data_req;
      grant_fetch = if_req & ~data_req;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_FETCH;
      cnt_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      // Strobes and completion pulses are single-cycle unless set below.
      ram_en_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (grant_data || grant_fetch) begin
            owner_q     <= grant_data ? OWN_DATA : OWN_FETCH;
            ram_en_q    <= 1'b1;
            // A simultaneous read and write performs the write only.
            ram_we_q    <= grant_data & mem_wr;
            ram_addr_q  <= grant_data ? mem_addr : if_addr;
            ram_wdata_q <= grant_data ? mem_wdata : '0;
            cnt_q       <= (grant_data && mem_wr) ? 3'd1 : 3'(RD_LATENCY);
            state_q     <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (!ram_we_q) begin
              if (owner_q == OWN_DATA) begin
                mem_rdata_q <= ram_rdata;
              end else begin
                if_rdata_q <= ram_rdata;
              end
            end
            // Valid is raised on the way into RESP so it is visible for
            // exactly the single RESP cycle.
            if (owner_q == OWN_DATA) begin
              mem_valid_q <= 1'b1;
            end else begin
              if_valid_q <= 1'b1;
            end
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            state_q     <= S_RESP;
          end
        end

        // RESP never grants, so a request still held after its valid pulse
        // cannot be issued a second time on this edge.
        S_RESP: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_valid  = if_valid_q;
  assign mem_valid = mem_valid_q;

  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = data_req & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. u_dut runs with RD_LATENCY=1 and
// u_dut3 with RD_LATENCY=3; both share clk and reset. The RAM model is
// combinational on ram_addr: address 0x4 returns 0x8C010000, and every other
// address A returns {16'hA5A5, A[15:0]}.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        stall_if;
  logic        stall_mem;

  logic        l3_if_req = 1'b0;
  logic [31:0] l3_if_addr = '0;
  logic [31:0] l3_if_rdata;
  logic        l3_if_valid;
  logic        l3_mem_rd = 1'b0;
  logic        l3_mem_wr = 1'b0;
  logic [31:0] l3_mem_addr = '0;
  logic [31:0] l3_mem_wdata = '0;
  logic [31:0] l3_mem_rdata;
  logic        l3_mem_valid;
  logic        l3_ram_en;
  logic        l3_ram_we;
  logic [31:0] l3_ram_addr;
  logic [31:0] l3_ram_wdata;
  logic [31:0] l3_ram_rdata;
  logic        l3_stall_if;
  logic        l3_stall_mem;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] ram_model(input logic [31:0] a);
    return (a == 32'h4) ? 32'h8C01_0000 : {16'hA5A5, a[15:0]};
  endfunction

  assign ram_rdata    = ram_model(ram_addr);
  assign l3_ram_rdata = ram_model(l3_ram_addr);

  mem_port_arbiter #(.RD_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.RD_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_rdata(l3_if_rdata), .if_valid(l3_if_valid),
    .mem_rd(l3_mem_rd), .mem_wr(l3_mem_wr), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata), .mem_valid(l3_mem_valid),
    .ram_en(l3_ram_en), .ram_we(l3_ram_we), .ram_addr(l3_ram_addr), .ram_wdata(l3_ram_wdata),
    .ram_rdata(l3_ram_rdata), .stall_if(l3_stall_if), .stall_mem(l3_stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) tick();
    n_checks++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== 66'h0) $display("FAIL rst_ram: got %h want 0", {ram_en, ram_we, ram_addr, ram_wdata}); else n_pass++;
    n_checks++; if ({if_valid, mem_valid} !== 2'b00) $display("FAIL rst_valid: got %b want 00", {if_valid, mem_valid}); else n_pass++;
    n_checks++; if ({if_rdata, mem_rdata} !== 64'h0) $display("FAIL rst_rdata: got %h want 0", {if_rdata, mem_rdata}); else n_pass++;
    n_checks++; if ({stall_if, stall_mem} !== 2'b00) $display("FAIL rst_stall: got %b want 00", {stall_if, stall_mem}); else n_pass++;
    n_checks++; if ({l3_ram_en, l3_ram_we, l3_ram_addr, l3_ram_wdata} !== 66'h0) $display("FAIL rst_l3_ram: got %h want 0", {l3_ram_en, l3_ram_we, l3_ram_addr, l3_ram_wdata}); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (ram_en !== 1'b0) $display("FAIL rst_idle_no_req: ram_en got %b want 0", ram_en); else n_pass++;
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 32'h4;
    tick();
    n_checks++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 32'h4}) $display("FAIL fetch_issue: got %h want %h", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 32'h4}); else n_pass++;
    n_checks++; if ({stall_if, if_valid} !== 2'b10) $display("FAIL fetch_stall_c1: got %b want 10", {stall_if, if_valid}); else n_pass++;
    tick();
    n_checks++; if (if_valid !== 1'b1) $display("FAIL fetch_valid: got %b want 1", if_valid); else n_pass++;
    n_checks++; if (if_rdata !== 32'h8C01_0000) $display("FAIL fetch_rdata: got %h want 8c010000", if_rdata); else n_pass++;
    n_checks++; if ({ram_en, stall_if, mem_valid} !== 3'b000) $display("FAIL fetch_c2_misc: got %b want 000", {ram_en, stall_if, mem_valid}); else n_pass++;
    if_req = 1'b0;
    tick();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL fetch_pulse_len: got %b want 0", if_valid); else n_pass++;
    n_checks++; if (if_rdata !== 32'h8C01_0000) $display("FAIL fetch_rdata_hold: got %h want 8c010000", if_rdata); else n_pass++;
  endtask

  task automatic test_priority;
    if_req = 1'b1; if_addr = 32'h8;
    mem_rd = 1'b1; mem_addr = 32'h10;
    tick();
    n_checks++; if ({ram_en, ram_addr} !== {1'b1, 32'h10}) $display("FAIL prio_data_first: got %h want %h", {ram_en, ram_addr}, {1'b1, 32'h10}); else n_pass++;
    n_checks++; if ({stall_if, stall_mem} !== 2'b11) $display("FAIL prio_stall_c1: got %b want 11", {stall_if, stall_mem}); else n_pass++;
    tick();
    n_checks++; if ({mem_valid, if_valid, stall_if, stall_mem} !== 4'b1010) $display("FAIL prio_c2_flags: got %b want 1010", {mem_valid, if_valid, stall_if, stall_mem}); else n_pass++;
    n_checks++; if (mem_rdata !== 32'hA5A5_0010) $display("FAIL prio_mem_rdata: got %h want a5a50010", mem_rdata); else n_pass++;
    mem_rd = 1'b0;
    tick();
    n_checks++; if ({ram_en, stall_if} !== 2'b01) $display("FAIL prio_resp_no_grant: got %b want 01", {ram_en, stall_if}); else n_pass++;
    tick();
    n_checks++; if ({ram_en, ram_addr, stall_if} !== {1'b1, 32'h8, 1'b1}) $display("FAIL prio_fetch_grant: got %h want %h", {ram_en, ram_addr, stall_if}, {1'b1, 32'h8, 1'b1}); else n_pass++;
    tick();
    n_checks++; if ({if_valid, if_rdata, stall_if} !== {1'b1, 32'hA5A5_0008, 1'b0}) $display("FAIL prio_fetch_done: got %h want %h", {if_valid, if_rdata, stall_if}, {1'b1, 32'hA5A5_0008, 1'b0}); else n_pass++;
    n_checks++; if (mem_rdata !== 32'hA5A5_0010) $display("FAIL prio_mem_rdata_hold: got %h want a5a50010", mem_rdata); else n_pass++;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_write;
    mem_wr = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
    tick();
    n_checks++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, 32'h20}) $display("FAIL wr_issue: got %h want %h", {ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 32'h20}); else n_pass++;
    n_checks++; if (ram_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_wdata: got %h want deadbeef", ram_wdata); else n_pass++;
    tick();
    n_checks++; if ({mem_valid, ram_we} !== 2'b10) $display("FAIL wr_valid_c2: got %b want 10", {mem_valid, ram_we}); else n_pass++;
    n_checks++; if (mem_rdata !== 32'hA5A5_0010) $display("FAIL wr_rdata_kept: got %h want a5a50010", mem_rdata); else n_pass++;
    mem_wr = 1'b0;
    tick();
    n_checks++; if (mem_valid !== 1'b0) $display("FAIL wr_pulse_len: got %b want 0", mem_valid); else n_pass++;
  endtask

  task automatic test_rd_wr_both;
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h30; mem_wdata = 32'h1234_5678;
    tick();
    n_checks++; if ({ram_we, ram_wdata} !== {1'b1, 32'h1234_5678}) $display("FAIL both_is_write: got %h want %h", {ram_we, ram_wdata}, {1'b1, 32'h1234_5678}); else n_pass++;
    tick();
    n_checks++; if ({mem_valid, mem_rdata} !== {1'b1, 32'hA5A5_0010}) $display("FAIL both_read_ignored: got %h want %h", {mem_valid, mem_rdata}, {1'b1, 32'hA5A5_0010}); else n_pass++;
    mem_rd = 1'b0; mem_wr = 1'b0;
    tick();
  endtask

  task automatic test_dropped;
    if_req = 1'b1; if_addr = 32'h50;
    tick();
    n_checks++; if (ram_en !== 1'b1) $display("FAIL drop_grant: ram_en got %b want 1", ram_en); else n_pass++;
    if_req = 1'b0;
    tick();
    n_checks++; if ({if_valid, if_rdata} !== {1'b1, 32'hA5A5_0050}) $display("FAIL drop_completes: got %h want %h", {if_valid, if_rdata}, {1'b1, 32'hA5A5_0050}); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [12:0] en_seen, vld_seen, en_exp, vld_exp;
    en_seen = '0; vld_seen = '0; en_exp = '0; vld_exp = '0;
    mem_rd = 1'b1; mem_addr = 32'h40;
    for (int k = 1; k <= 12; k++) begin
      tick();
      en_seen[k]  = ram_en;
      vld_seen[k] = mem_valid;
      en_exp[k]   = (k % 3 == 1);
      vld_exp[k]  = (k % 3 == 2);
    end
    mem_rd = 1'b0;
    n_checks++; if (en_seen !== en_exp) $display("FAIL b2b_grants: got %b want %b", en_seen, en_exp); else n_pass++;
    n_checks++; if (vld_seen !== vld_exp) $display("FAIL b2b_valids: got %b want %b", vld_seen, vld_exp); else n_pass++;
  endtask

  task automatic test_starvation;
    logic [31:0] exp_addr;
    int g;
    g = 0;
    mem_rd = 1'b1; mem_addr = 32'h60;
    if_req = 1'b1; if_addr = 32'h70;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k % 3 == 1) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_addr = (g % 5 == 4) ? 32'h70 : 32'h60;
`else
        exp_addr = 32'h60;
`endif
        n_checks++; if ({ram_en, ram_addr} !== {1'b1, exp_addr}) $display("FAIL starve_grant%0d: got %h want %h", g, {ram_en, ram_addr}, {1'b1, exp_addr}); else n_pass++;
        g++;
      end
    end
    mem_rd = 1'b0; if_req = 1'b0;
    tick();
  endtask

  task automatic test_lat3_reset;
    logic [2:0] vld_seen;
    l3_mem_rd = 1'b1; l3_mem_addr = 32'h80;
    tick();
    n_checks++; if (l3_ram_en !== 1'b1) $display("FAIL l3_issue: ram_en got %b want 1", l3_ram_en); else n_pass++;
    tick();
    n_checks++; if ({l3_ram_en, l3_ram_addr} !== {1'b0, 32'h80}) $display("FAIL l3_addr_hold: got %h want %h", {l3_ram_en, l3_ram_addr}, {1'b0, 32'h80}); else n_pass++;
    tick();
    n_checks++; if (l3_mem_valid !== 1'b0) $display("FAIL l3_early_valid: got %b want 0", l3_mem_valid); else n_pass++;
    tick();
    n_checks++; if ({l3_mem_valid, l3_mem_rdata} !== {1'b1, 32'hA5A5_0080}) $display("FAIL l3_read_done: got %h want %h", {l3_mem_valid, l3_mem_rdata}, {1'b1, 32'hA5A5_0080}); else n_pass++;
    l3_mem_rd = 1'b0;
    tick();
    l3_if_req = 1'b1; l3_if_addr = 32'h90;
    tick();
    n_checks++; if ({l3_ram_en, l3_ram_addr} !== {1'b1, 32'h90}) $display("FAIL l3_fetch_issue: got %h want %h", {l3_ram_en, l3_ram_addr}, {1'b1, 32'h90}); else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if ({l3_ram_en, l3_ram_we, l3_ram_addr, l3_ram_wdata} !== 66'h0) $display("FAIL l3_abort_ram: got %h want 0", {l3_ram_en, l3_ram_we, l3_ram_addr, l3_ram_wdata}); else n_pass++;
    n_checks++; if ({l3_if_valid, l3_mem_valid, l3_if_rdata, l3_mem_rdata} !== 66'h0) $display("FAIL l3_abort_out: got %h want 0", {l3_if_valid, l3_mem_valid, l3_if_rdata, l3_mem_rdata}); else n_pass++;
    n_checks++; if ({l3_stall_if, l3_stall_mem} !== 2'b10) $display("FAIL l3_abort_stall: got %b want 10", {l3_stall_if, l3_stall_mem}); else n_pass++;
    n_checks++; if (if_rdata !== 32'h0) $display("FAIL rst_clears_if_rdata: got %h want 0", if_rdata); else n_pass++;
    repeat (2) begin
      tick();
      n_checks++; if ({l3_if_valid, l3_ram_en} !== 2'b00) $display("FAIL l3_in_reset: got %b want 00", {l3_if_valid, l3_ram_en}); else n_pass++;
    end
    reset = 1'b1;
    tick();
    n_checks++; if ({l3_ram_en, l3_ram_addr, l3_if_valid} !== {1'b1, 32'h90, 1'b0}) $display("FAIL l3_regrant: got %h want %h", {l3_ram_en, l3_ram_addr, l3_if_valid}, {1'b1, 32'h90, 1'b0}); else n_pass++;
    vld_seen = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vld_seen[k] = l3_if_valid;
    end
    n_checks++; if (vld_seen !== 3'b100) $display("FAIL l3_regrant_latency: got %b want 100", vld_seen); else n_pass++;
    n_checks++; if (l3_if_rdata !== 32'hA5A5_0090) $display("FAIL l3_regrant_rdata: got %h want a5a50090", l3_if_rdata); else n_pass++;
    l3_if_req = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_write();
    test_rd_wr_both();
    test_dropped();
    test_back_to_back();
    test_starvation();
    test_lat3_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
